// File: rtl/mu0_control.sv
`default_nettype none
// ============================================================================
// mu0_control : MU0 fetch/execute sequencer, opcode decode, memory-wait
//               stretching and retired-instruction counter.
// Revision    : 1.0
// ============================================================================
module mu0_control (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  input  logic        Mem_Ack,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic        PC_En,
  output logic        IR_En,
  output logic        Acc_En,
  output logic [1:0]  M,
  output logic        MEM_rd,
  output logic        MEM_wr,
  output logic        Halted,
  output logic [15:0] Instr_Count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_PASS_Y = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_INC_X  = 2'b10;
  localparam logic [1:0] ALU_SUB    = 2'b11;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        mem_op;
  logic        exec_done;

  always_comb begin
    X_sel     = 1'b0;
    Y_sel     = 1'b0;
    Addr_sel  = 1'b0;
    PC_En     = 1'b0;
    IR_En     = 1'b0;
    Acc_En    = 1'b0;
    M         = ALU_PASS_Y;
    MEM_rd    = 1'b0;
    MEM_wr    = 1'b0;
    state_d   = state_q;
    count_d   = count_q;
    mem_op    = (F == OP_LDA) || (F == OP_STA) || (F == OP_ADD) || (F == OP_SUB);
    exec_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Instruction read from PC while the ALU computes PC+1.
        Addr_sel = 1'b0;
        MEM_rd   = 1'b1;
        X_sel    = 1'b1;
        M        = ALU_INC_X;
        if (Mem_Ack) begin
          IR_En   = 1'b1;
          PC_En   = 1'b1;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (F)
          OP_LDA: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            Acc_En   = Mem_Ack;
          end
          OP_STA: begin
            Addr_sel = 1'b1;
            MEM_wr   = 1'b1;
          end
          OP_ADD: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            M        = ALU_ADD;
            Acc_En   = Mem_Ack;
          end
          OP_SUB: begin
            Addr_sel = 1'b1;
            MEM_rd   = 1'b1;
            M        = ALU_SUB;
            Acc_En   = Mem_Ack;
          end
          OP_JMP: begin
            Y_sel = 1'b1;
            PC_En = 1'b1;
          end
          OP_JGE: begin
            Y_sel = 1'b1;
            PC_En = ~N;
          end
          OP_JNE: begin
            Y_sel = 1'b1;
            PC_En = ~Z;
          end
          default: begin
          end
        endcase

        // Memory opcodes stall here; F comes from IR so outputs stay stable.
        exec_done = mem_op ? Mem_Ack : 1'b1;
        if (exec_done) begin
          count_d = count_q + 16'd1;
          state_d = (F == OP_STP) ? S_HALT : S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign Halted      = (state_q == S_HALT);
  assign Instr_Count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mu0_control.sv
`default_nettype none
// Self-checking bench for mu0_control: directed vector table, hand-written
// wait/halt sequences and randomized cycles against a behavioural model.
module tb_mu0_control;

  logic        Clk;
  logic        Reset;
  logic [3:0]  F;
  logic        N;
  logic        Z;
  logic        Mem_Ack;
  logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En;
  logic [1:0]  M;
  logic        MEM_rd, MEM_wr, Halted;
  logic [15:0] Instr_Count;

  mu0_control dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .F           (F),
    .N           (N),
    .Z           (Z),
    .Mem_Ack     (Mem_Ack),
    .X_sel       (X_sel),
    .Y_sel       (Y_sel),
    .Addr_sel    (Addr_sel),
    .PC_En       (PC_En),
    .IR_En       (IR_En),
    .Acc_En      (Acc_En),
    .M           (M),
    .MEM_rd      (MEM_rd),
    .MEM_wr      (MEM_wr),
    .Halted      (Halted),
    .Instr_Count (Instr_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output bundle order: X Y Addr PC_En IR_En Acc_En M[1:0] RD WR Halted
  logic [10:0] dut_out;
  assign dut_out = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, MEM_rd, MEM_wr, Halted};

  localparam logic [10:0] O_FETCH_ACK  = 11'b10011010100;
  localparam logic [10:0] O_FETCH_WAIT = 11'b10000010100;
  localparam logic [10:0] O_LDA_ACK    = 11'b00100100100;
  localparam logic [10:0] O_JMP_TAKEN  = 11'b01010000000;
  localparam logic [10:0] O_JMP_NOT    = 11'b01000000000;
  localparam logic [10:0] O_STA        = 11'b00100000010;
  localparam logic [10:0] O_ADD_WAIT   = 11'b00100001100;
  localparam logic [10:0] O_ADD_ACK    = 11'b00100101100;
  localparam logic [10:0] O_NONE       = 11'b00000000000;
  localparam logic [10:0] O_HALTED     = 11'b00000000001;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] f, input logic n, input logic z, input logic ack);
    Reset   = rst;
    F       = f;
    N       = n;
    Z       = z;
    Mem_Ack = ack;
    #2;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic        ack;
    logic        chk;
    logic [10:0] exp_out;
    logic [15:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [3:0] f, logic n, logic z, logic ack,
                              logic chk, logic [10:0] eo, logic [15:0] ec);
    vec_t v;
    v.rst = rst; v.f = f; v.n = n; v.z = z; v.ack = ack;
    v.chk = chk; v.exp_out = eo; v.exp_cnt = ec;
    return v;
  endfunction

  // Behavioural reference: the controller is either waiting to fetch, holding
  // a fetched instruction, or halted; outputs follow from opcode properties.
  function automatic logic [10:0] model_out(bit halted, bit have_instr, logic [3:0] f,
                                            bit n, bit z, bit ack);
    bit         rd, wr, jump, pc;
    logic [1:0] m;
    if (halted) return O_HALTED;
    if (!have_instr) return {1'b1, 1'b0, 1'b0, ack, ack, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
    rd   = (f == 4'd0) || (f == 4'd2) || (f == 4'd3);
    wr   = (f == 4'd1);
    jump = (f == 4'd4) || (f == 4'd5) || (f == 4'd6);
    pc   = (f == 4'd4) || ((f == 4'd5) && !n) || ((f == 4'd6) && !z);
    m    = (f == 4'd2) ? 2'b01 : (f == 4'd3) ? 2'b11 : 2'b00;
    return {1'b0, jump, rd | wr, pc, 1'b0, rd & ack, m, rd, wr, 1'b0};
  endfunction

  vec_t vecs[17];

  initial begin
    bit          m_halted, m_have;
    int          m_cnt;
    logic [3:0]  cur_f;
    bit          r_rst, r_n, r_z, r_ack;
    logic [10:0] exp;

    vecs[0]  = mk(1, 4'd0,  0, 0, 0, 0, O_NONE,       16'd0);
    vecs[1]  = mk(0, 4'd0,  0, 0, 1, 1, O_FETCH_ACK,  16'd0);
    vecs[2]  = mk(0, 4'd0,  0, 0, 1, 1, O_LDA_ACK,    16'd0);
    vecs[3]  = mk(0, 4'd5,  0, 0, 1, 1, O_FETCH_ACK,  16'd1);
    vecs[4]  = mk(0, 4'd5,  0, 0, 0, 1, O_JMP_TAKEN,  16'd1);
    vecs[5]  = mk(0, 4'd5,  1, 0, 1, 1, O_FETCH_ACK,  16'd2);
    vecs[6]  = mk(0, 4'd5,  1, 0, 1, 1, O_JMP_NOT,    16'd2);
    vecs[7]  = mk(0, 4'd6,  0, 1, 1, 1, O_FETCH_ACK,  16'd3);
    vecs[8]  = mk(0, 4'd6,  0, 1, 1, 1, O_JMP_NOT,    16'd3);
    vecs[9]  = mk(0, 4'd1,  0, 0, 1, 1, O_FETCH_ACK,  16'd4);
    vecs[10] = mk(0, 4'd1,  0, 0, 0, 1, O_STA,        16'd4);
    vecs[11] = mk(0, 4'd1,  0, 0, 1, 1, O_STA,        16'd4);
    vecs[12] = mk(0, 4'hC,  0, 0, 0, 1, O_FETCH_WAIT, 16'd5);
    vecs[13] = mk(1, 4'hC,  0, 0, 0, 1, O_FETCH_WAIT, 16'd5);
    vecs[14] = mk(0, 4'hC,  0, 0, 1, 1, O_FETCH_ACK,  16'd0);
    vecs[15] = mk(0, 4'hC,  0, 0, 1, 1, O_NONE,       16'd0);
    vecs[16] = mk(0, 4'hC,  0, 0, 0, 1, O_FETCH_WAIT, 16'd1);

    Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0; Mem_Ack = 1'b0;
    tick();

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].f, vecs[i].n, vecs[i].z, vecs[i].ack);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_out", i), {21'd0, dut_out}, {21'd0, vecs[i].exp_out});
        check($sformatf("vec%0d_cnt", i), {16'd0, Instr_Count}, {16'd0, vecs[i].exp_cnt});
      end
      tick();
    end

    // ADD with three wait states: 5 cycles total including fetch.
    drive(0, 4'd2, 0, 0, 1);
    check("add_fetch", {21'd0, dut_out}, {21'd0, O_FETCH_ACK});
    tick();
    for (int w = 0; w < 3; w++) begin
      drive(0, 4'd2, 0, 0, 0);
      check($sformatf("add_wait%0d", w), {21'd0, dut_out}, {21'd0, O_ADD_WAIT});
      tick();
    end
    drive(0, 4'd2, 0, 0, 1);
    check("add_ack", {21'd0, dut_out}, {21'd0, O_ADD_ACK});
    check("add_cnt_before", {16'd0, Instr_Count}, 32'd1);
    tick();
    drive(0, 4'd7, 0, 0, 0);
    check("add_back_fetch", {21'd0, dut_out}, {21'd0, O_FETCH_WAIT});
    check("add_cnt_after", {16'd0, Instr_Count}, 32'd2);

    // STP then halted with toggling acknowledge, then reset.
    drive(0, 4'd7, 0, 0, 1);
    tick();
    drive(0, 4'd7, 0, 0, 1);
    check("stp_exec", {21'd0, dut_out}, {21'd0, O_NONE});
    tick();
    for (int h = 0; h < 10; h++) begin
      drive(0, 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'(h & 1));
      check($sformatf("halt%0d_out", h), {21'd0, dut_out}, {21'd0, O_HALTED});
      check($sformatf("halt%0d_cnt", h), {16'd0, Instr_Count}, 32'd3);
      tick();
    end
    drive(1, 4'd0, 0, 0, 1);
    tick();
    drive(0, 4'd0, 0, 0, 1);
    check("post_halt_reset_out", {21'd0, dut_out}, {21'd0, O_FETCH_ACK});
    check("post_halt_reset_cnt", {16'd0, Instr_Count}, 32'd0);
    drive(1, 4'd0, 0, 0, 0);
    tick();

    // Randomized run against the behavioural model.
    m_halted = 0; m_have = 0; m_cnt = 0; cur_f = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 63) == 0);
      r_n   = 1'($urandom);
      r_z   = 1'($urandom);
      r_ack = ($urandom_range(0, 2) != 0);
      if (!m_have) cur_f = 4'($urandom_range(0, 15));
      drive(r_rst, cur_f, r_n, r_z, r_ack);
      exp = model_out(m_halted, m_have, cur_f, r_n, r_z, r_ack);
      check("rand_out", {21'd0, dut_out}, {21'd0, exp});
      check("rand_cnt", {16'd0, Instr_Count}, 32'(m_cnt & 16'hFFFF));
      if (r_rst) begin
        m_halted = 0; m_have = 0; m_cnt = 0;
      end else if (!m_halted) begin
        if (!m_have) begin
          if (r_ack) m_have = 1;
        end else if (!((cur_f <= 4'd3) && !r_ack)) begin
          m_cnt++;
          m_have = 0;
          if (cur_f == 4'd7) m_halted = 1;
        end
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
